// File: rtl/port_afu_rst_sequencer.sv
// Per-port AFU soft-reset sequencer: gates new TX packets at a packet boundary,
// drains outstanding host reads (bounded by a timeout), then pulses the port reset.
module port_afu_rst_sequencer #(
   parameter int unsigned NUM_PORTS      = 4,
   parameter int unsigned CNT_W          = 10,
   parameter int unsigned RST_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_PORTS-1:0]         i_rst_req,
   input  logic [NUM_PORTS-1:0]         i_sop_hs,
   input  logic [NUM_PORTS-1:0]         i_eop_hs,
   input  logic [NUM_PORTS-1:0]         i_rd_req_hs,
   input  logic [NUM_PORTS-1:0]         i_cpl_last_hs,
   output logic [NUM_PORTS-1:0]         o_tx_gate,
   output logic [NUM_PORTS-1:0]         o_port_rst_n,
   output logic [NUM_PORTS-1:0]         o_busy,
   output logic [NUM_PORTS-1:0]         o_timeout,
   output logic [NUM_PORTS-1:0]         o_cnt_err,
   output logic [NUM_PORTS*CNT_W-1:0]   o_outstanding
);

   localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_BLOCK,
      ST_DRAIN,
      ST_RESET
   } state_e;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      state_e            state_q, state_d;
      logic [RC_W-1:0]   rcnt_q, rcnt_d;
      logic [TO_W-1:0]   tcnt_q, tcnt_d;
      logic [CNT_W-1:0]  out_q, out_d;
      logic              in_pkt_q, in_pkt_d;
      logic              tmo_q, tmo_d;
      logic              err_q, err_d;
      logic              gate_q, prst_q, busy_q;
      logic              inc, dec;

      assign inc = i_rd_req_hs[p] & ~i_cpl_last_hs[p];
      assign dec = i_cpl_last_hs[p] & ~i_rd_req_hs[p];

      always_comb begin
         state_d  = state_q;
         rcnt_d   = rcnt_q;
         tcnt_d   = tcnt_q;
         out_d    = out_q;
         tmo_d    = tmo_q;
         err_d    = err_q;
         in_pkt_d = in_pkt_q;

         if (i_eop_hs[p]) begin
            in_pkt_d = 1'b0;
         end else if (i_sop_hs[p]) begin
            in_pkt_d = 1'b1;
         end

         // The AFU is held in reset, so any packet in flight is abandoned.
         if (state_q == ST_RESET) begin
            out_d    = '0;
            in_pkt_d = 1'b0;
         end else if (inc) begin
            if (out_q == '1) begin
               err_d = 1'b1;
            end else begin
               out_d = out_q + 1'b1;
            end
         end else if (dec) begin
            if (out_q == '0) begin
               err_d = 1'b1;
            end else begin
               out_d = out_q - 1'b1;
            end
         end

         case (state_q)
            ST_RUN: begin
               if (i_rst_req[p]) begin
                  tmo_d   = 1'b0;
                  tcnt_d  = '0;
                  state_d = in_pkt_d ? ST_BLOCK : ST_DRAIN;
               end
            end
            ST_BLOCK: begin
               if (i_eop_hs[p]) begin
                  tcnt_d  = '0;
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // An empty count wins over an expiring timer in the same cycle.
               if (out_d == '0) begin
                  rcnt_d  = RC_W'(RST_CYCLES);
                  state_d = ST_RESET;
               end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  tmo_d   = 1'b1;
                  rcnt_d  = RC_W'(RST_CYCLES);
                  state_d = ST_RESET;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            default: begin
               if (rcnt_q == RC_W'(1)) begin
                  state_d = ST_RUN;
               end else begin
                  rcnt_d = rcnt_q - 1'b1;
               end
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q  <= ST_RESET;
            rcnt_q   <= RC_W'(RST_CYCLES);
            tcnt_q   <= '0;
            out_q    <= '0;
            in_pkt_q <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
            gate_q   <= 1'b0;
            prst_q   <= 1'b0;
            busy_q   <= 1'b1;
         end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            tcnt_q   <= tcnt_d;
            out_q    <= out_d;
            in_pkt_q <= in_pkt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            gate_q   <= (state_d == ST_RUN);
            prst_q   <= (state_d != ST_RESET);
            busy_q   <= (state_d != ST_RUN);
         end
      end

      assign o_tx_gate[p]                    = gate_q;
      assign o_port_rst_n[p]                 = prst_q;
      assign o_busy[p]                       = busy_q;
      assign o_timeout[p]                    = tmo_q;
      assign o_cnt_err[p]                    = err_q;
      assign o_outstanding[p*CNT_W +: CNT_W] = out_q;
   end

endmodule

// File: tb/tb_port_afu_rst_sequencer.sv
// Self-checking bench for port_afu_rst_sequencer: directed sequences, a vector table
// and randomized traffic checked against a behavioural per-port model.
module tb_port_afu_rst_sequencer;
   localparam int NP = 4;
   localparam int CW = 10;
   localparam int RC = 16;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst_n;
   logic [NP-1:0]    req, sop, eop, rd, cpl;
   logic [NP-1:0]    gate, prst, busy, tmo, cerr;
   logic [NP*CW-1:0] outs;
   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   port_afu_rst_sequencer #(
      .NUM_PORTS(NP), .CNT_W(CW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_rst_req(req), .i_sop_hs(sop), .i_eop_hs(eop),
      .i_rd_req_hs(rd), .i_cpl_last_hs(cpl),
      .o_tx_gate(gate), .o_port_rst_n(prst), .o_busy(busy),
      .o_timeout(tmo), .o_cnt_err(cerr), .o_outstanding(outs)
   );

   // Behavioural model: reset cycles left, waiting-for-tlast flag, drain age (-1 = not draining)
   int m_rst_left[NP];
   bit m_block[NP];
   int m_age[NP];
   int m_cnt[NP];
   bit m_pkt[NP], m_tmo[NP], m_err[NP];

   function automatic bit m_running(int p);
      return (m_rst_left[p] == 0) && !m_block[p] && (m_age[p] < 0);
   endfunction

   function automatic void model_reset();
      for (int p = 0; p < NP; p++) begin
         m_rst_left[p] = RC; m_block[p] = 0; m_age[p] = -1;
         m_cnt[p] = 0; m_pkt[p] = 0; m_tmo[p] = 0; m_err[p] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int p = 0; p < NP; p++) begin
         bit run = m_running(p);
         if (m_rst_left[p] > 0) begin
            m_cnt[p] = 0; m_pkt[p] = 0; m_rst_left[p]--;
         end else begin
            if (rd[p] && !cpl[p]) begin
               if (m_cnt[p] == (1 << CW) - 1) m_err[p] = 1; else m_cnt[p]++;
            end else if (cpl[p] && !rd[p]) begin
               if (m_cnt[p] == 0) m_err[p] = 1; else m_cnt[p]--;
            end
            if (eop[p]) m_pkt[p] = 0; else if (sop[p]) m_pkt[p] = 1;
            if (run) begin
               if (req[p]) begin
                  m_tmo[p] = 0;
                  if (m_pkt[p]) m_block[p] = 1; else m_age[p] = 0;
               end
            end else if (m_block[p]) begin
               if (eop[p]) begin m_block[p] = 0; m_age[p] = 0; end
            end else begin
               if (m_cnt[p] == 0) begin
                  m_age[p] = -1; m_rst_left[p] = RC;
               end else if (m_age[p] + 1 == TO) begin
                  m_tmo[p] = 1; m_age[p] = -1; m_rst_left[p] = RC;
               end else begin
                  m_age[p]++;
               end
            end
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("model tx_gate[%0d]", p), 32'(gate[p]), 32'(m_running(p)));
         chk($sformatf("model port_rst_n[%0d]", p), 32'(prst[p]), 32'(m_rst_left[p] == 0));
         chk($sformatf("model busy[%0d]", p), 32'(busy[p]), 32'(!m_running(p)));
         chk($sformatf("model timeout[%0d]", p), 32'(tmo[p]), 32'(m_tmo[p]));
         chk($sformatf("model cnt_err[%0d]", p), 32'(cerr[p]), 32'(m_err[p]));
         chk($sformatf("model outstanding[%0d]", p), 32'(outs[p*CW +: CW]), m_cnt[p]);
      end
   endtask

   task automatic clr();
      req = '0; sop = '0; eop = '0; rd = '0; cpl = '0;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   typedef struct {
      logic req, sop, eop;
      logic exp_gate, exp_rst_n, exp_busy;
   } vec_t;
   vec_t tbl[25];

   initial begin
      // Port 1: SOP at row 0, request at row 2, tlast at row 4+... row 7
      for (int i = 0; i < 25; i++) begin
         tbl[i].req = 0; tbl[i].sop = 0; tbl[i].eop = 0;
         if (i < 2 || i == 24) begin
            tbl[i].exp_gate = 1; tbl[i].exp_rst_n = 1; tbl[i].exp_busy = 0;
         end else if (i < 8) begin
            tbl[i].exp_gate = 0; tbl[i].exp_rst_n = 1; tbl[i].exp_busy = 1;
         end else begin
            tbl[i].exp_gate = 0; tbl[i].exp_rst_n = 0; tbl[i].exp_busy = 1;
         end
      end
      tbl[0].sop = 1;
      tbl[2].req = 1;
      tbl[7].eop = 1;

      clr();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      chk("por port_rst_n", 32'(prst), 0);
      chk("por tx_gate", 32'(gate), 0);
      chk("por busy", 32'(busy), 32'hF);
      rst_n = 1'b1;
      for (int i = 1; i <= RC; i++) begin
         cycle();
         if (i == RC - 1) chk("por still low", 32'(prst), 0);
      end
      chk("por released", 32'(prst), 32'hF);
      chk("por gate", 32'(gate), 32'hF);
      chk("por busy clear", 32'(busy), 0);
      chk("por outstanding", 32'(outs), 0);

      // Idle port 0 reset, with a request during RESET that must be ignored
      req[0] = 1; cycle(); clr();
      chk("p0 drain gate", 32'(gate[0]), 0);
      chk("p0 drain rst_n", 32'(prst[0]), 1);
      for (int i = 1; i <= RC; i++) begin
         if (i == 5) req[0] = 1;
         cycle(); clr();
         chk("p0 pulse low", 32'(prst[0]), 0);
         chk("p1 stays run", 32'(gate[1]), 1);
      end
      cycle();
      chk("p0 back to run", 32'(prst[0]), 1);
      chk("p0 gate run", 32'(gate[0]), 1);
      repeat (4) cycle();
      chk("p0 req not queued", 32'(busy[0]), 0);

      // Port 1 packet-boundary blocking from the vector table
      for (int i = 0; i < 25; i++) begin
         req[1] = tbl[i].req; sop[1] = tbl[i].sop; eop[1] = tbl[i].eop;
         cycle(); clr();
         chk($sformatf("tbl[%0d] gate", i), 32'(gate[1]), 32'(tbl[i].exp_gate));
         chk($sformatf("tbl[%0d] rst_n", i), 32'(prst[1]), 32'(tbl[i].exp_rst_n));
         chk($sformatf("tbl[%0d] busy", i), 32'(busy[1]), 32'(tbl[i].exp_busy));
      end

      // Request coincident with SOP-without-EOP blocks
      req[1] = 1; sop[1] = 1; cycle(); clr();
      chk("p1 coincident busy", 32'(busy[1]), 1);
      repeat (3) begin
         cycle();
         chk("p1 coincident blocked", 32'(prst[1]), 1);
      end
      eop[1] = 1; cycle(); clr();
      cycle();
      chk("p1 coincident rst", 32'(prst[1]), 0);
      repeat (RC) cycle();
      chk("p1 coincident run", 32'(gate[1]), 1);

      // Port 2 drains three reads
      rd[2] = 1; repeat (3) cycle(); clr();
      chk("p2 three reads", 32'(outs[2*CW +: CW]), 3);
      req[2] = 1; cycle(); clr();
      for (int k = 1; k <= 30; k++) begin
         if (k == 10 || k == 20 || k == 30) cpl[2] = 1;
         cycle(); clr();
         if (k == 29) chk("p2 still draining", 32'(prst[2]), 1);
      end
      chk("p2 reset begins", 32'(prst[2]), 0);
      chk("p2 drained count", 32'(outs[2*CW +: CW]), 0);
      chk("p2 no timeout", 32'(tmo[2]), 0);
      repeat (RC) cycle();
      chk("p2 run", 32'(gate[2]), 1);

      // Port 3 drain timeout
      rd[3] = 1; cycle(); clr();
      req[3] = 1; cycle(); clr();
      for (int k = 1; k <= TO; k++) begin
         cycle();
         if (k == TO - 1) begin
            chk("p3 pre-timeout rst_n", 32'(prst[3]), 1);
            chk("p3 pre-timeout flag", 32'(tmo[3]), 0);
         end
      end
      chk("p3 timeout rst_n", 32'(prst[3]), 0);
      chk("p3 timeout flag", 32'(tmo[3]), 1);
      repeat (RC) cycle();
      chk("p3 run after timeout", 32'(gate[3]), 1);
      chk("p3 count cleared", 32'(outs[3*CW +: CW]), 0);
      chk("p3 timeout sticky", 32'(tmo[3]), 1);
      req[3] = 1; cycle(); clr();
      chk("p3 timeout cleared", 32'(tmo[3]), 0);
      repeat (RC + 1) cycle();
      chk("p3 run again", 32'(gate[3]), 1);

      // Port 0 counter corner cases
      rd[0] = 1; cycle(); clr();
      rd[0] = 1; cpl[0] = 1; cycle(); clr();
      chk("p0 rd+cpl unchanged", 32'(outs[CW-1:0]), 1);
      cpl[0] = 1; cycle(); clr();
      chk("p0 count zero", 32'(outs[CW-1:0]), 0);
      chk("p0 no err yet", 32'(cerr[0]), 0);
      cpl[0] = 1; cycle(); clr();
      chk("p0 underflow err", 32'(cerr[0]), 1);
      chk("p0 underflow sat", 32'(outs[CW-1:0]), 0);

      // Port 1 overflow saturation
      rd[1] = 1;
      repeat ((1 << CW) - 1) cycle();
      chk("p1 full count", 32'(outs[CW +: CW]), (1 << CW) - 1);
      chk("p1 no overflow yet", 32'(cerr[1]), 0);
      cycle(); clr();
      chk("p1 overflow err", 32'(cerr[1]), 1);
      chk("p1 overflow sat", 32'(outs[CW +: CW]), (1 << CW) - 1);
      cpl[1] = 1; repeat ((1 << CW) - 1) cycle(); clr();

      // Randomized traffic, with one asynchronous reset mid-run
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all();
            repeat (2) begin
               @(posedge clk);
               #1;
               check_all();
            end
            rst_n = 1'b1;
         end
         for (int p = 0; p < NP; p++) begin
            req[p] = ($urandom_range(0, 39) == 0);
            sop[p] = ($urandom_range(0, 7) == 0);
            eop[p] = ($urandom_range(0, 5) == 0);
            rd[p]  = ($urandom_range(0, 3) == 0);
            cpl[p] = ($urandom_range(0, 3) == 0);
         end
         cycle();
      end
      clr();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
